// File: rtl/fpu_host_if.sv
// fpu_host_if: 8-bit host register front-end with command/result FIFOs feeding the FPU core.
// Optional core watchdog: define FPU_HOST_TIMEOUT_EN.
module fpu_host_if #(
  parameter int DATA_W         = 32,
  parameter int OP_W           = 4,
  parameter int ADDR_W         = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [7:0]        databus_in,
  output logic [7:0]        databus_out,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic              end_ack,
  output logic              cmd_end,
  output logic              busy,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  output logic [OP_W-1:0]   core_op,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result
);
  localparam int NB  = DATA_W / 8;
  localparam int CW  = 2 * DATA_W + OP_W;
  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RES_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_OP     = ADDR_W'(2 * NB);
  localparam logic [ADDR_W-1:0] ADDR_CMD    = ADDR_W'(2 * NB + 1);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3 * NB + 1);
  localparam logic [DATA_W-1:0] QNAN = (DATA_W == 64) ? DATA_W'(64'h7FF8000000000000)
                                                      : DATA_W'(32'h7FC00000);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [DATA_W-1:0] a_r, b_r;
  logic [OP_W-1:0]   op_r;
  logic [CW-1:0]     cmd_mem [CMD_DEPTH];
  logic [CPW-1:0]    cmd_wp_r, cmd_rp_r;
  logic [CPW:0]      cmd_cnt_r;
  logic [DATA_W-1:0] res_mem [RES_DEPTH];
  logic [RPW-1:0]    res_wp_r, res_rp_r;
  logic [RPW:0]      res_cnt_r;
  logic              wr_prev_r, ack_prev_r, ovf_r, to_r, cmd_end_r, busy_r, core_start_r;
  logic [1:0]        state_r;
  logic [DATA_W-1:0] core_a_r, core_b_r;
  logic [OP_W-1:0]   core_op_r;

  logic              wr_stb_s, cmd_wr_s, cmd_push_s, cmd_pop_s, res_done_s, res_pop_s, to_hit_s;
  logic              cmd_full_s, cmd_empty_s, res_full_s, res_empty_s;
  logic [DATA_W-1:0] res_din_s;
  logic [7:0]        status_s, rd_data_s;

  // Strobe edge detection and FIFO push/pop decisions for this cycle.
  always_comb begin
    wr_stb_s    = !cs && !wr && wr_prev_r;
    cmd_full_s  = (cmd_cnt_r == (CPW+1)'(CMD_DEPTH));
    cmd_empty_s = (cmd_cnt_r == '0);
    res_full_s  = (res_cnt_r == (RPW+1)'(RES_DEPTH));
    res_empty_s = (res_cnt_r == '0);
    cmd_wr_s    = wr_stb_s && (addr == ADDR_CMD);
    cmd_push_s  = cmd_wr_s && !cmd_full_s;
    cmd_pop_s   = (state_r == ISSUE);
    res_done_s  = (state_r == WAIT) && (core_done || to_hit_s);
    res_din_s   = core_done ? core_result : QNAN;
    res_pop_s   = end_ack && !ack_prev_r && !res_empty_s;
    status_s    = {3'b000, to_r, ovf_r, res_empty_s, cmd_empty_s, cmd_full_s};
  end

  // Host read path: combinational byte select, zero when not strobed or unmapped.
  always_comb begin
    rd_data_s = 8'h00;
    if (!cs && !rd) begin
      for (int i = 0; i < NB; i++) begin
        if (addr == ADDR_W'(i)) begin
          rd_data_s = a_r[8*i +: 8];
        end else if (addr == ADDR_W'(NB + i)) begin
          rd_data_s = b_r[8*i +: 8];
        end else if ((addr == ADDR_W'(2*NB + 1 + i)) && !res_empty_s) begin
          rd_data_s = res_mem[res_rp_r][8*i +: 8];
        end else begin
          rd_data_s = rd_data_s;
        end
      end
      if (addr == ADDR_OP) begin
        rd_data_s = 8'(op_r);
      end else if (addr == ADDR_STATUS) begin
        rd_data_s = status_s;
      end else begin
        rd_data_s = rd_data_s;
      end
    end else begin
      rd_data_s = 8'h00;
    end
  end

  assign databus_out = rd_data_s;

  // Operand registers, sticky status bits and strobe history.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      a_r <= '0; b_r <= '0; op_r <= '0;
      wr_prev_r <= 1'b1; ack_prev_r <= 1'b0; ovf_r <= 1'b0; to_r <= 1'b0;
    end else begin
      wr_prev_r  <= wr;
      ack_prev_r <= end_ack;
      if (wr_stb_s) begin
        for (int i = 0; i < NB; i++) begin
          if (addr == ADDR_W'(i)) a_r[8*i +: 8] <= databus_in;
          if (addr == ADDR_W'(NB + i)) b_r[8*i +: 8] <= databus_in;
        end
        if (addr == ADDR_OP) op_r <= OP_W'(databus_in);
      end
      if (wr_stb_s && (addr == ADDR_STATUS)) begin
        ovf_r <= 1'b0;
        to_r  <= 1'b0;
      end else begin
        if (cmd_wr_s && cmd_full_s) ovf_r <= 1'b1;
        if (to_hit_s) to_r <= 1'b1;
      end
    end
  end

  // Command FIFO: entries are {A, B, OP}.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < CMD_DEPTH; i++) cmd_mem[i] <= '0;
      cmd_wp_r <= '0; cmd_rp_r <= '0; cmd_cnt_r <= '0;
    end else begin
      if (cmd_push_s) begin
        cmd_mem[cmd_wp_r] <= {a_r, b_r, op_r};
        cmd_wp_r <= cmd_wp_r + CPW'(1);
      end
      if (cmd_pop_s) cmd_rp_r <= cmd_rp_r + CPW'(1);
      case ({cmd_push_s, cmd_pop_s})
        2'b10:   cmd_cnt_r <= cmd_cnt_r + (CPW+1)'(1);
        2'b01:   cmd_cnt_r <= cmd_cnt_r - (CPW+1)'(1);
        default: cmd_cnt_r <= cmd_cnt_r;
      endcase
    end
  end

  // Result FIFO, drained by end_ack rising edges.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < RES_DEPTH; i++) res_mem[i] <= '0;
      res_wp_r <= '0; res_rp_r <= '0; res_cnt_r <= '0;
    end else begin
      if (res_done_s) begin
        res_mem[res_wp_r] <= res_din_s;
        res_wp_r <= res_wp_r + RPW'(1);
      end
      if (res_pop_s) res_rp_r <= res_rp_r + RPW'(1);
      case ({res_done_s, res_pop_s})
        2'b10:   res_cnt_r <= res_cnt_r + (RPW+1)'(1);
        2'b01:   res_cnt_r <= res_cnt_r - (RPW+1)'(1);
        default: res_cnt_r <= res_cnt_r;
      endcase
    end
  end

  // Issue FSM; IDLE has nothing in flight, so a free result slot guarantees room for the answer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r <= IDLE; core_start_r <= 1'b0;
      core_a_r <= '0; core_b_r <= '0; core_op_r <= '0;
      cmd_end_r <= 1'b0; busy_r <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      cmd_end_r    <= !res_empty_s;
      busy_r       <= !cmd_empty_s || (state_r != IDLE);
      case (state_r)
        IDLE:  if (!cmd_empty_s && !res_full_s) state_r <= ISSUE;
        ISSUE: begin
          core_a_r     <= cmd_mem[cmd_rp_r][CW-1 -: DATA_W];
          core_b_r     <= cmd_mem[cmd_rp_r][OP_W +: DATA_W];
          core_op_r    <= cmd_mem[cmd_rp_r][OP_W-1:0];
          core_start_r <= 1'b1;
          state_r      <= WAIT;
        end
        WAIT:    if (res_done_s) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef FPU_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_r;

  // Watchdog: counts WAIT cycles without a completion pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      to_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign to_hit_s = (state_r == WAIT) && !core_done && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
  assign to_hit_s = 1'b0;
`endif

  assign cmd_end    = cmd_end_r;
  assign busy       = busy_r;
  assign core_a     = core_a_r;
  assign core_b     = core_b_r;
  assign core_op    = core_op_r;
  assign core_start = core_start_r;
endmodule
